// File: rtl/writeback_buffer_pkg.sv
// wb_pkg: shared defaults and entry type for the writeback buffer.
package wb_pkg;
    localparam int WB_DEPTH  = 4;
    localparam int WB_DATA_W = 16;
    localparam int WB_IDX_W  = 2;

    typedef struct packed {
        logic [WB_IDX_W-1:0]  index;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int wb_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if: producer, register-file and lookup signals of the writeback buffer.
interface writeback_buffer_if
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int IDX_W  = WB_IDX_W
);
    logic                        in_valid;
    logic                        in_ready;
    logic [IDX_W-1:0]            in_index;
    logic [DATA_W-1:0]           in_data;
    logic                        flush;
    logic                        rf_stall;
    logic                        rf_write_enable;
    logic [IDX_W-1:0]            rf_write_index;
    logic [DATA_W-1:0]           rf_write_data;
    logic [IDX_W-1:0]            lookup_index;
    logic                        lookup_hit;
    logic [DATA_W-1:0]           lookup_data;
    logic [wb_count_w(DEPTH)-1:0] count;

    modport master (
        output in_valid, in_index, in_data, flush, rf_stall, lookup_index,
        input  in_ready, rf_write_enable, rf_write_index, rf_write_data,
               lookup_hit, lookup_data, count
    );
    modport slave (
        input  in_valid, in_index, in_data, flush, rf_stall, lookup_index,
        output in_ready, rf_write_enable, rf_write_index, rf_write_data,
               lookup_hit, lookup_data, count
    );
endinterface

// File: rtl/writeback_buffer_mem.sv
// writeback_buffer_mem: entry storage, one write port and a read tap per slot.
module writeback_buffer_mem
    import wb_pkg::*;
#(
    parameter int  DEPTH = WB_DEPTH,
    parameter type T     = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  T                         i_wdata,
    output T                         o_taps [DEPTH]
);
    T r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_taps = r_mem;
endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order register writeback FIFO with stall, flush and optional
// youngest-match lookup bypass (enabled by WRITEBACK_BYPASS_EN).
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int IDX_W  = WB_IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    writeback_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = IDX_W + DATA_W;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_taps [DEPTH];
    logic [EW-1:0] w_head;

    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign w_empty = r_count == '0;
    // Ready is gated by reset so the producer sees a closed door while held in reset.
    assign bus.in_ready        = reset && !w_full;
    assign w_push              = bus.in_valid && bus.in_ready && !bus.flush;
    assign bus.rf_write_enable = !w_empty && !bus.rf_stall && !bus.flush;
    assign w_pop               = bus.rf_write_enable;
    assign w_head              = w_empty ? '0 : w_taps[r_rd_ptr];
    assign {bus.rf_write_index, bus.rf_write_data} = w_head;
    assign bus.count           = r_count;

    writeback_buffer_mem #(
        .DEPTH (DEPTH),
        .T     (logic [EW-1:0])
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({bus.in_index, bus.in_data}),
        .o_taps  (w_taps)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end

`ifdef WRITEBACK_BYPASS_EN
    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        bus.lookup_hit  = 1'b0;
        bus.lookup_data = '0;
        for (int k = 0; k < DEPTH; k++)
            if ((AW+1)'(k) < r_count &&
                w_taps[r_rd_ptr + AW'(k)][EW-1 -: IDX_W] == bus.lookup_index) begin
                bus.lookup_hit  = 1'b1;
                bus.lookup_data = w_taps[r_rd_ptr + AW'(k)][DATA_W-1:0];
            end
    end
`else
    assign bus.lookup_hit  = 1'b0;
    assign bus.lookup_data = '0;
`endif
endmodule
